rr_arbiter_4: RTL
=================

# rr_arbiter_4

Four-requester round-robin arbiter that owns a shared 4:1 data multiplexer. Grants the shared output channel to one requester at a time for a whole packet (terminated by `last`), drives the mux select, and rotates priority so no requester starves. Sits between four producer ports and a single downstream consumer with a valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, 8: width of each requester's data word and of `out_data`.
- `MAX_HOLD`, 16: maximum cycles one grant may be held (used only with `ARB_TIMEOUT_EN`); must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  per-requester valid; requester i has a word pending.
- `last`  in  4  per-requester end-of-packet flag, qualified by `req[i]`.
- `in_data`  in  4*DATA_W  packed words; requester i at bits [i*DATA_W +: DATA_W].
- `in_ready`  out  4  per-requester ready = `gnt[i] & out_ready`.
- `gnt`  out  4  registered one-hot grant; all-zero when idle.
- `sel`  out  2  registered mux select (index of granted requester).
- `out_valid`  out  1  `req[sel]` while granted, else 0.
- `out_data`  out  DATA_W  `in_data` word of requester `sel` (combinational through the mux).
- `out_last`  out  1  `last[sel]` while granted, else 0.
- `out_ready`  in  1  downstream accepts word when `out_valid & out_ready`.
- `busy`  out  1  high in GRANT state.
- `timeout`  out  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, GRANT. Round-robin pointer `ptr` (2 bits) = index with highest priority.
- IDLE: if `req != 0`, pick first set bit scanning `ptr, ptr+1, ptr+2, ptr+3` (mod 4); register `gnt`, `sel`; go to GRANT. If `req == 0`, stay; `gnt = 0`.
- GRANT: beat transfers when `out_valid & out_ready`. Release (→ IDLE, `gnt = 0`, `ptr = sel+1` mod 4) when any of:
  - beat transfers with `out_last = 1`;
  - `req[sel] == 0` (requester abandoned; no beat lost, since none offered);
  - timeout (see Configuration).
- Otherwise hold grant; other requests ignored regardless of priority.
- `ptr` wraps 3 → 0. `ptr` never changes except on release.
- Reset (any state, including mid-packet): state IDLE, `gnt = 0`, `sel = 0`, `ptr = 0`, hold counter 0, `busy = 0`, `timeout = 0`; `out_valid`, `out_last`, `in_ready` therefore 0.

## Timing
- Request at cycle N in IDLE → `gnt`/`sel`/`busy` valid at N+1; first possible transfer at N+1.
- Release decided in cycle M → IDLE at M+1; earliest next grant at M+2 (one dead cycle per packet, deliberate).
- Single-beat packet: one GRANT cycle if `out_ready` high.
- Simultaneous release and new requests: new requests evaluated in IDLE against updated `ptr`.
- `out_valid`/`out_data`/`out_last` combinational from inputs and registered `sel`; no registers in the data path.

## Configuration
- `ARB_TIMEOUT_EN` defined: counter `hold_cnt` (width $clog2(MAX_HOLD)) clears on entering GRANT, increments each GRANT cycle; at `hold_cnt == MAX_HOLD-1` with no `out_last` transfer that cycle, force release and pulse `timeout`. A transfer in that cycle still completes.
- Not defined: no counter; grant held until `last` or abandonment; `timeout` tied 0.

## Structure
- Shared package `arb_pkg`: state typedef (IDLE, GRANT), `NUM_REQ = 4`, `SEL_W = 2`.
- One sub-module `rr_pick4`: combinational rotating-priority picker (inputs `req`, `ptr`; outputs `found`, `idx`). Mux and FSM in the top.

## Test plan
- Reset, `req=4'b0101`, `last` high, `out_ready=1` → grants 0 then 2 then 0, each at N+1, one idle cycle between.
- `req=4'b1111`, all single-beat → grant order 0,1,2,3,0; `ptr` wraps 3→0.
- Requester 1 sends 5-beat packet, `out_ready` low every other cycle, `req[3]` high throughout → `gnt` stays `4'b0010` until 5th accepted beat with `last`, then `4'b1000`.
- Requester 2 granted, drops `req[2]` mid-packet → release next cycle, `ptr=3`, no `timeout`.
- `ARB_TIMEOUT_EN`, `MAX_HOLD=4`, requester 0 never asserts `last` → `timeout` pulse in 4th GRANT cycle, `gnt=0` next cycle, then requester 1 (if requesting) granted.
- `rst` asserted mid-packet → next cycle `gnt=0`, `sel=0`, `busy=0`, then grant restarts from requester 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-requester round-robin arbiter.
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);
    // Scan from lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(k);
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_4.sv
// Packet-granular round-robin arbiter driving a shared 4:1 data mux.
// Define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        last,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      timeout
);
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_arbiter_4: MAX_HOLD must be >= 2");
    end

    state_t                            state;
    logic [SEL_W-1:0]                  ptr;
    logic [NUM_REQ-1:0][DATA_W-1:0]    words;
    logic                              found;
    logic [SEL_W-1:0]                  pick;
    logic                              xfer_last;
    logic                              hold_to;
    logic                              release_now;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    // Data path is purely combinational behind the registered select.
    assign words     = in_data;
    assign busy      = (state == GRANT);
    assign out_valid = busy & req[sel];
    assign out_last  = out_valid & last[sel];
    assign out_data  = words[sel];
    assign in_ready  = gnt & {NUM_REQ{out_ready}};
    assign xfer_last = out_last & out_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt;

    // Counter sits at zero in IDLE so it reads 0 in the first GRANT cycle.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + HOLD_W'(1);
    end

    assign hold_to = busy & (hold_cnt == HOLD_W'(MAX_HOLD-1)) & ~xfer_last;
`else
    assign hold_to = 1'b0;
`endif

    assign timeout     = hold_to;
    assign release_now = xfer_last | ~req[sel] | hold_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        gnt   <= NUM_REQ'(1) << pick;
                        sel   <= pick;
                    end else begin
                        gnt   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state <= IDLE;
                        gnt   <= '0;
                        ptr   <= sel + SEL_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end
endmodule
